postproc_s2mm: RTL
==================

POSTPROC_S2MM -- requirements
Module: postproc_s2mm

Interface
REQ-001 SHALL have parameter DATA_W, default 64, stream and AXI write data width in bits (power of two, 32..512).
REQ-002 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-003 SHALL have parameter LEN_W, default 16, command length field width (beats).
REQ-004 SHALL have parameter MAX_BURST, default 16, maximum beats per AXI burst (power of two, 1..256).
REQ-005 SHALL have port aclk  input  1  single clock for all logic.
REQ-006 SHALL have port aresetn  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port cmd_valid  input  1  command offered.
REQ-008 SHALL have port cmd_ready  output  1  block idle, command accepted on valid&ready.
REQ-009 SHALL have port cmd_addr  input  ADDR_W  destination byte address.
REQ-010 SHALL have port cmd_len  input  LEN_W  transfer length in beats.
REQ-011 SHALL have port s_axis_tdata  input  DATA_W  postproc stream data.
REQ-012 SHALL have port s_axis_tvalid  input  1  stream beat valid.
REQ-013 SHALL have port s_axis_tready  output  1  stream beat accepted.
REQ-014 SHALL have port s_axis_tlast  input  1  final beat of stream packet.
REQ-015 SHALL have port m_axi_awaddr  output  ADDR_W  burst start address.
REQ-016 SHALL have port m_axi_awlen  output  8  beats minus one.
REQ-017 SHALL have port m_axi_awvalid  output  1  / m_axi_awready  input  1  AW handshake.
REQ-018 SHALL have port m_axi_wdata  output  DATA_W  write data.
REQ-019 SHALL have port m_axi_wlast  output  1  last beat of burst.
REQ-020 SHALL have port m_axi_wvalid  output  1  / m_axi_wready  input  1  W handshake.
REQ-021 SHALL have port m_axi_bresp  input  2  / m_axi_bvalid  input  1  / m_axi_bready  output  1  B handshake.
REQ-022 SHALL have port done  output  1  one-cycle pulse at command completion; err  output  1  valid with done.

Function
REQ-023 SHALL implement FSM IDLE -> AW -> W -> B -> (AW if beats remain, else DONE) -> IDLE; cmd_ready=1 only in IDLE.
REQ-024 SHALL force cmd_addr low log2(DATA_W/8) bits to zero; drive awsize=log2(DATA_W/8), awburst=INCR, wstrb all ones.
REQ-025 SHALL size each burst as min(MAX_BURST, beats remaining, beats to next 4 KB boundary); no burst crosses 4 KB.
REQ-026 SHALL hold awaddr/awlen stable and awvalid high in AW until awready; next address = previous + (awlen+1)*DATA_W/8.
REQ-027 SHALL in W connect wvalid=s_axis_tvalid, s_axis_tready=m_axi_wready, wdata=tdata combinationally (zero latency); both 0 outside W.
REQ-028 SHALL assert wlast on the final beat of each burst; move to B on wvalid&wready&wlast.
REQ-029 SHALL hold bready=1 in B only; one burst outstanding at a time.
REQ-030 SHALL latch sticky error on any bresp != OKAY, continue remaining bursts, and report err=1 with done.
REQ-031 SHALL for cmd_len=0 pulse done the cycle after acceptance, err=0, no AXI traffic.
REQ-032 SHALL pulse done exactly once per command, in DONE state; cmd_ready returns the following cycle.

Reset
REQ-033 SHALL, while aresetn=0, force FSM IDLE, counters/error 0, and all outputs (including cmd_ready, awvalid, wvalid, bready, s_axis_tready, done, err) to 0; cmd_ready=1 first cycle after release.
REQ-034 SHALL on reset mid-command abandon the command silently (no done).

Configuration
REQ-035 SHALL, with S2MM_TLAST_CHECK_EN defined, set error when tlast is seen before the command's final beat or is absent on it; beat count still governs termination.
REQ-036 SHALL, without S2MM_TLAST_CHECK_EN, ignore s_axis_tlast entirely.

Structure
REQ-037 SHALL take AXI resp codes, burst/size encodings and the 4 KB boundary constant from accel_core_pkg.
REQ-038 SHALL be one flat module; no sub-module.

Verification
REQ-039 addr 0x1000, len 40, DATA_W 64 -> bursts awlen 15,15,7 at 0x1000,0x1080,0x1100; one done, err=0.
REQ-040 addr 0x0FF0, len 4 -> awlen 1 at 0x0FF0, awlen 1 at 0x1000.
REQ-041 len 0 -> done next cycle, awvalid never asserted.
REQ-042 len 32, bresp SLVERR on burst 2 -> all 32 beats written, done with err=1.
REQ-043 random tvalid gaps and wready stalls, len 100 -> data order preserved, exactly 100 W beats.
REQ-044 S2MM_TLAST_CHECK_EN, len 8, tlast on beat 5 -> 8 beats written, done with err=1.

Source files
------------

// File: rtl/accel_core_pkg.sv
// Shared AXI encodings, the 4 KB boundary constant and the S2MM state type
// used by the accelerator datapath blocks.
package accel_core_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

  localparam int unsigned AXI_4K_BOUNDARY = 4096;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AW,
    S_W,
    S_B,
    S_DONE
  } s2mm_state_e;

  // AxSIZE encoding for a beat of the given byte count.
  function automatic logic [2:0] axi_size_enc(input int unsigned bytes);
    return 3'($clog2(bytes));
  endfunction

endpackage

// File: rtl/postproc_s2mm.sv
// Stream-to-memory-mapped writer: splits a (addr, len) command into 4 KB-safe
// AXI INCR bursts fed straight from the stream. Optional tlast checking is
// enabled with the S2MM_TLAST_CHECK_EN macro.
module postproc_s2mm
  import accel_core_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 32,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic                  done,
  output logic                  err
);

  localparam int BYTES   = DATA_W / 8;
  localparam int BYTE_SH = $clog2(BYTES);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES - 1);

  s2mm_state_e       state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic [7:0]        awlen_q, awlen_d;
  logic [7:0]        beat_q, beat_d;
  logic              err_q, err_d;

  logic [8:0]        nb_idle, nb_next;
  logic              w_hs, wlast;

  // Beats in the next burst: limited by MAX_BURST, the beats left and the 4 KB page end.
  function automatic logic [8:0] burst_beats(input logic [ADDR_W-1:0] a,
                                             input logic [LEN_W-1:0]  rem);
    logic [31:0] to_bnd;
    logic [31:0] n;
    to_bnd = (32'(AXI_4K_BOUNDARY) - 32'(a[11:0])) >> BYTE_SH;
    n      = 32'(MAX_BURST);
    if (32'(rem) < n)
      n = 32'(rem);
    if (to_bnd < n)
      n = to_bnd;
    return n[8:0];
  endfunction

  assign nb_idle = burst_beats(cmd_addr & ALIGN_MASK, cmd_len);
  assign nb_next = burst_beats(addr_q, remain_q);

  assign w_hs  = (state_q == S_W) && s_axis_tvalid && m_axi_wready;
  assign wlast = (state_q == S_W) && (beat_q == awlen_q);

`ifndef S2MM_TLAST_CHECK_EN
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
`endif

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    awlen_d  = awlen_q;
    beat_d   = beat_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d   = cmd_addr & ALIGN_MASK;
          remain_d = cmd_len;
          err_d    = 1'b0;
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else begin
            awlen_d = 8'(nb_idle - 9'd1);
            state_d = S_AW;
          end
        end
      end
      S_AW: begin
        if (m_axi_awready) begin
          addr_d  = addr_q + ((ADDR_W'(awlen_q) + ADDR_W'(1)) << BYTE_SH);
          beat_d  = 8'd0;
          state_d = S_W;
        end
      end
      S_W: begin
        if (w_hs) begin
          remain_d = remain_q - LEN_W'(1);
          beat_d   = beat_q + 8'd1;
`ifdef S2MM_TLAST_CHECK_EN
          // tlast must coincide exactly with the command's final beat.
          if (s_axis_tlast != (remain_q == LEN_W'(1)))
            err_d = 1'b1;
`endif
          if (wlast)
            state_d = S_B;
        end
      end
      S_B: begin
        if (m_axi_bvalid) begin
          if (m_axi_bresp != AXI_RESP_OKAY)
            err_d = 1'b1;
          if (remain_q == '0) begin
            state_d = S_DONE;
          end else begin
            awlen_d = 8'(nb_next - 9'd1);
            state_d = S_AW;
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      awlen_q  <= '0;
      beat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      awlen_q  <= awlen_d;
      beat_q   <= beat_d;
      err_q    <= err_d;
    end
  end

  // cmd_ready is qualified by reset so it reads 0 while reset is held.
  assign cmd_ready     = aresetn && (state_q == S_IDLE);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = awlen_q;
  assign m_axi_awsize  = axi_size_enc(BYTES);
  assign m_axi_awburst = AXI_BURST_INCR;
  assign m_axi_awvalid = (state_q == S_AW);
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wstrb   = '1;
  assign m_axi_wlast   = wlast;
  assign m_axi_wvalid  = (state_q == S_W) && s_axis_tvalid;
  assign s_axis_tready = (state_q == S_W) && m_axi_wready;
  assign m_axi_bready  = (state_q == S_B);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_DONE) && err_q;

endmodule
